phase_deserializer: RTL and testbench

PHASE_DESERIALIZER -- requirements
Module: phase_deserializer

---
 rtl/phase_deserializer_pkg.sv | 14 +
 rtl/phase_deserializer_nibble_assembler.sv | 54 +++++
 rtl/phase_deserializer.sv | 84 ++++++++
 tb/tb_phase_deserializer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/phase_deserializer_pkg.sv
// phase_deserializer_pkg: shared FSM encoding, nibble width and frame-size helpers
package phase_deserializer_pkg;
  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
  localparam int NIB_W = 4;
  function automatic int frame_bits(int n);
    return NIB_W * n;
  endfunction
  function automatic int cnt_w(int n);
    return $clog2(NIB_W * n + 1);
  endfunction
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/phase_deserializer_nibble_assembler.sv
// nibble_assembler: groups captured frame bits into nibbles and pulses nib_valid per nibble
//   sclk/rst_n : clock, async active-low reset
//   first      : first bit of a frame (restarts bit and nibble counters)
//   en         : a further frame bit is captured this cycle
//   din        : the bit being captured
//   nib_valid  : one-cycle pulse after the 4th bit of a nibble
//   nib_data   : completed nibble, first-received bit in [3]
//   nib_idx    : index of the completed nibble within the frame
module nibble_assembler
  import phase_deserializer_pkg::*;
#(
  parameter int n = 210
) (
  input  logic                  sclk,
  input  logic                  rst_n,
  input  logic                  first,
  input  logic                  en,
  input  logic                  din,
  output logic                  nib_valid,
  output logic [NIB_W-1:0]      nib_data,
  output logic [idx_w(n)-1:0]   nib_idx
);
  localparam int IW = idx_w(n);
  logic [2:0]    sh;
  logic [1:0]    bc;
  logic [IW-1:0] idx;
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sh        <= '0;
      bc        <= '0;
      idx       <= '0;
      nib_valid <= 1'b0;
      nib_data  <= '0;
      nib_idx   <= '0;
    end else begin
      nib_valid <= 1'b0;
      if (first) begin
        sh  <= {2'b00, din};
        bc  <= 2'd1;
        idx <= '0;
      end else if (en) begin
        sh <= {sh[1:0], din};
        bc <= bc + 2'd1;
        if (bc == 2'd3) begin
          nib_valid <= 1'b1;
          nib_data  <= {sh, din};
          nib_idx   <= idx;
          // saturate so the index never wraps inside a frame
          idx       <= (idx == IW'(n - 1)) ? idx : idx + IW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/phase_deserializer.sv
// phase_deserializer: serial MSB-first frame receiver producing a 4*n-bit pattern
//   sclk/rst_n  : clock, async active-low reset
//   data_in     : serial frame bit, valid when load=1
//   load        : bit-valid strobe; must stay high for a whole frame
//   clr         : synchronous abort of a frame in progress
//   pattern     : last complete frame, first bit at the MSB
//   frame_valid : one-cycle pulse when pattern updates
//   nib_valid/nib_data/nib_idx : per-nibble completion strobe, data and index
//   short_err   : sticky, load dropped mid-frame
//   overrun     : sticky, load held high after frame completion
//   busy        : high while receiving
module phase_deserializer
  import phase_deserializer_pkg::*;
#(
  parameter int n = 210
) (
  input  logic                sclk,
  input  logic                rst_n,
  input  logic                data_in,
  input  logic                load,
  input  logic                clr,
  output logic [4*n-1:0]      pattern,
  output logic                frame_valid,
  output logic                nib_valid,
  output logic [NIB_W-1:0]    nib_data,
  output logic [idx_w(n)-1:0] nib_idx,
  output logic                short_err,
  output logic                overrun,
  output logic                busy
);
  localparam int FB = frame_bits(n);
  localparam int CW = cnt_w(n);
  state_t        state, nxt;
  logic [CW-1:0] count;
  logic [FB-1:0] shreg;
  logic          start, shift, last, abort, ovr, at_last;
  assign at_last = (count == CW'(FB - 1));
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end
  always_comb begin
    nxt = clr              ? IDLE :
          (state == IDLE)  ? (load ? RECV : IDLE) :
          (state == RECV)  ? (!load ? IDLE : at_last ? DONE : RECV) :
                             (load ? DONE : IDLE);
  end
  always_comb begin
    busy  = (state == RECV);
    start = !clr && load && (state == IDLE);
    shift = !clr && load && (state == RECV);
    last  = shift && at_last;
    abort = !clr && !load && (state == RECV);
    ovr   = !clr && load && (state == DONE);
  end
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      shreg       <= '0;
      pattern     <= '0;
      frame_valid <= 1'b0;
      short_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_valid <= last;
      // the count only matters while receiving, so every other cycle zeroes it
      count       <= start ? CW'(1) : shift ? count + CW'(1) : '0;
      if (start || shift) shreg <= {shreg[FB-2:0], data_in};
      if (last) pattern <= {shreg[FB-2:0], data_in};
      short_err   <= start ? 1'b0 : (short_err | abort);
      overrun     <= start ? 1'b0 : (overrun | ovr);
    end
  end
  nibble_assembler #(.n(n)) u_nib (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .first     (start),
    .en        (shift),
    .din       (data_in),
    .nib_valid (nib_valid),
    .nib_data  (nib_data),
    .nib_idx   (nib_idx)
  );
endmodule

// File: tb/tb_phase_deserializer.sv
// tb_phase_deserializer: directed and randomized checks of phase_deserializer for n=2 and n=210
module tb_phase_deserializer;
  logic         sclk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_a = 1'b0, data_a = 1'b0, clr_a = 1'b0;
  logic [7:0]   pat_a;
  logic         fv_a, nv_a, se_a, ov_a, busy_a;
  logic [3:0]   nd_a;
  logic [0:0]   ni_a;
  logic         load_b = 1'b0, data_b = 1'b0, clr_b = 1'b0;
  logic [839:0] pat_b;
  logic         fv_b, nv_b, se_b, ov_b, busy_b;
  logic [3:0]   nd_b;
  logic [7:0]   ni_b;
  int           passed = 0, total = 0;
  logic [7:0]   exp_pat = '0;

  always #5 sclk = ~sclk;

  phase_deserializer #(.n(2)) dut_a (
    .sclk(sclk), .rst_n(rst_n), .data_in(data_a), .load(load_a), .clr(clr_a),
    .pattern(pat_a), .frame_valid(fv_a), .nib_valid(nv_a), .nib_data(nd_a),
    .nib_idx(ni_a), .short_err(se_a), .overrun(ov_a), .busy(busy_a)
  );

  phase_deserializer #(.n(210)) dut_b (
    .sclk(sclk), .rst_n(rst_n), .data_in(data_b), .load(load_b), .clr(clr_b),
    .pattern(pat_b), .frame_valid(fv_b), .nib_valid(nv_b), .nib_data(nd_b),
    .nib_idx(ni_b), .short_err(se_b), .overrun(ov_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [839:0] got, input logic [839:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc_a(input logic l, input logic d, input logic c);
    load_a = l;
    data_a = d;
    clr_a  = c;
    @(posedge sclk);
    #1;
  endtask

  // k bits with load high (k<8 is a short frame), then extra overrun cycles, then one load-low cycle
  task automatic frame_a(input logic [7:0] v, input int k, input int extra);
    for (int j = 1; j <= k; j++) begin
      cyc_a(1'b1, v[8-j], 1'b0);
      chk($sformatf("frame_valid bit%0d", j), fv_a, j == 8);
      chk($sformatf("nib_valid bit%0d", j), nv_a, (j % 4) == 0);
      if ((j % 4) == 0) begin
        chk($sformatf("nib_data bit%0d", j), nd_a, (v >> (8 - j)) & 8'h0F);
        chk($sformatf("nib_idx bit%0d", j), ni_a, j / 4 - 1);
      end
      chk($sformatf("busy bit%0d", j), busy_a, j < 8);
      if (j == 1) begin
        chk("short_err cleared at start", se_a, 0);
        chk("overrun cleared at start", ov_a, 0);
      end
      chk($sformatf("pattern bit%0d", j), pat_a, (j == 8) ? v : exp_pat);
    end
    if (k == 8) exp_pat = v;
    for (int e = 1; e <= extra; e++) begin
      cyc_a(1'b1, 1'($urandom), 1'b0);
      chk("overrun set", ov_a, 1);
      chk("overrun no frame_valid", fv_a, 0);
      chk("overrun no nib_valid", nv_a, 0);
      chk("overrun pattern held", pat_a, exp_pat);
      chk("overrun not busy", busy_a, 0);
    end
    cyc_a(1'b0, 1'($urandom), 1'b0);
    chk("end short_err", se_a, k < 8);
    chk("end overrun", ov_a, extra > 0);
    chk("end busy", busy_a, 0);
    chk("end frame_valid", fv_a, 0);
    chk("end pattern", pat_a, exp_pat);
  endtask

  initial begin
    logic [7:0]   v;
    logic [839:0] fr;
    int           kind, pulses;
    #2;
    chk("reset pattern", pat_a, 0);
    chk("reset frame_valid", fv_a, 0);
    chk("reset nib_valid", nv_a, 0);
    chk("reset nib_data", nd_a, 0);
    chk("reset nib_idx", ni_a, 0);
    chk("reset short_err", se_a, 0);
    chk("reset overrun", ov_a, 0);
    chk("reset busy", busy_a, 0);
    chk("reset pattern big", pat_b, 0);
    @(posedge sclk);
    #1;
    rst_n = 1'b1;
    cyc_a(1'b0, 1'b1, 1'b0);
    chk("idle ignores data", busy_a, 0);

    frame_a(8'hA7, 8, 0);
    frame_a(8'h5B, 5, 0);
    frame_a(8'h3C, 8, 0);
    frame_a(8'h96, 8, 2);
    frame_a(8'h55, 8, 0);

    v = 8'hE1;
    for (int j = 1; j <= 3; j++) cyc_a(1'b1, v[8-j], 1'b0);
    cyc_a(1'b1, v[4], 1'b1);
    chk("clr busy", busy_a, 0);
    chk("clr nib_valid", nv_a, 0);
    chk("clr short_err", se_a, 0);
    chk("clr overrun", ov_a, 0);
    cyc_a(1'b1, v[3], 1'b0);
    chk("clr restarts frame", busy_a, 1);
    chk("clr no frame_valid", fv_a, 0);
    chk("clr pattern held", pat_a, exp_pat);
    cyc_a(1'b0, 1'b0, 1'b0);
    frame_a(8'h3A, 8, 0);

    v = 8'hD2;
    for (int j = 1; j <= 5; j++) cyc_a(1'b1, v[8-j], 1'b0);
    load_a = 1'b1;
    data_a = v[2];
    #3;
    rst_n = 1'b0;
    #1;
    chk("async reset pattern", pat_a, 0);
    chk("async reset busy", busy_a, 0);
    chk("async reset frame_valid", fv_a, 0);
    chk("async reset nib_valid", nv_a, 0);
    chk("async reset nib_data", nd_a, 0);
    chk("async reset nib_idx", ni_a, 0);
    chk("async reset short_err", se_a, 0);
    chk("async reset overrun", ov_a, 0);
    exp_pat = '0;
    load_a = 1'b0;
    @(posedge sclk);
    #1;
    rst_n = 1'b1;
    cyc_a(1'b0, 1'b0, 1'b0);
    chk("post reset short_err", se_a, 0);
    frame_a(8'hC3, 8, 0);

    for (int t = 0; t < 24; t++) begin
      v = 8'($urandom);
      kind = int'($urandom_range(0, 2));
      if (kind == 0) frame_a(v, int'($urandom_range(1, 7)), 0);
      else if (kind == 1) frame_a(v, 8, 0);
      else frame_a(v, 8, int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 2)) cyc_a(1'b0, 1'($urandom), 1'b0);
      chk("gap pattern held", pat_a, exp_pat);
    end

    for (int k = 0; k < 210; k++) fr[839-4*k -: 4] = (k == 17) ? 4'h0 : 4'h8;
    pulses = 0;
    for (int j = 1; j <= 840; j++) begin
      load_b = 1'b1;
      data_b = fr[840-j];
      @(posedge sclk);
      #1;
      if (nv_b) pulses++;
      if ((j % 4) == 0) begin
        chk($sformatf("big nib_valid %0d", j / 4 - 1), nv_b, 1);
        chk($sformatf("big nib_idx %0d", j / 4 - 1), ni_b, j / 4 - 1);
        chk($sformatf("big nib_data %0d", j / 4 - 1), nd_b, (j / 4 - 1 == 17) ? 4'h0 : 4'h8);
      end
      if (j == 840) begin
        chk("big frame_valid", fv_b, 1);
        chk("big pattern", pat_b, fr);
      end
    end
    load_b = 1'b0;
    @(posedge sclk);
    #1;
    if (nv_b) pulses++;
    chk("big nib pulse count", pulses, 210);
    chk("big frame_valid pulse", fv_b, 0);
    chk("big short_err", se_b, 0);
    chk("big overrun", ov_b, 0);
    chk("big pattern held", pat_b, fr);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
